// File: rtl/issue_queue_pkg.sv
// Shared core widths and sequence-number age helpers for the issue queue slice.
package issue_queue_pkg;

  localparam int TAG_W     = 7;
  localparam int SQN_W     = 7;
  localparam int FU_W      = 4;
  localparam int CONST_BIT = 6;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [SQN_W-1:0] sqn_t;
  typedef logic [FU_W-1:0]  fu_t;

  // Wrapping comparison: a is younger than b when the signed distance is positive.
  function automatic logic is_younger(input sqn_t a, input sqn_t b);
    sqn_t diff;
    diff = a - b;
    return (diff[SQN_W-1] == 1'b0) && (diff != {SQN_W{1'b0}});
  endfunction

  function automatic logic is_older(input sqn_t a, input sqn_t b);
    sqn_t diff;
    diff = a - b;
    return diff[SQN_W-1];
  endfunction

endpackage

// File: rtl/issue_queue_age_select.sv
// Oldest-ready picker: one-hot grant of the oldest requesting entry, lowest index on ties.
module iq_age_select
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]            req,
  input  logic [DEPTH-1:0][SQN_W-1:0] sqn,
  output logic [DEPTH-1:0]            grant,
  output logic                        found
);

  logic [DEPTH-1:0] grant_s;
  logic             found_s;
  sqn_t             best_s;

  // Linear scan; strict "older" keeps the lower index when ages are equal.
  always_comb begin
    grant_s = {DEPTH{1'b0}};
    found_s = 1'b0;
    best_s  = {SQN_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (req[i] && (!found_s || is_older(sqn[i], best_s))) begin
        grant_s    = {DEPTH{1'b0}};
        grant_s[i] = 1'b1;
        found_s    = 1'b1;
        best_s     = sqn[i];
      end else begin
        best_s = best_s;
      end
    end
  end

  assign grant = grant_s;
  assign found = found_s;

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue queue: tag wakeup, oldest-ready select, flush by sqN and a registered issue slot.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int NUM_WBS   = 4,
  parameter int PAYLOAD_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     IN_valid,
  input  logic [TAG_W-1:0]         IN_tagA,
  input  logic [TAG_W-1:0]         IN_tagB,
  input  logic [SQN_W-1:0]         IN_sqN,
  input  logic [FU_W-1:0]          IN_fu,
  input  logic [PAYLOAD_W-1:0]     IN_payload,
  input  logic [NUM_WBS-1:0]       IN_wbHasResult,
  input  logic [NUM_WBS*TAG_W-1:0] IN_wbTag,
  input  logic                     IN_invalidate,
  input  logic [SQN_W-1:0]         IN_invalidateSqN,
  input  logic                     IN_stall,
  output logic                     OUT_full,
  output logic [$clog2(DEPTH):0]   OUT_count,
  output logic                     OUT_uopValid,
  output logic [TAG_W-1:0]         OUT_tagA,
  output logic [TAG_W-1:0]         OUT_tagB,
  output logic [SQN_W-1:0]         OUT_sqN,
  output logic [FU_W-1:0]          OUT_fu,
  output logic [PAYLOAD_W-1:0]     OUT_payload
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  function automatic logic wb_hit(input tag_t tag, input logic [NUM_WBS-1:0] has,
                                  input logic [NUM_WBS*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < NUM_WBS; j++) begin
      hit = hit | (has[j] && (tags[j*TAG_W +: TAG_W] == tag));
    end
    return hit;
  endfunction

  logic [DEPTH-1:0]                valid_r;
  logic [DEPTH-1:0]                avail_a_r;
  logic [DEPTH-1:0]                avail_b_r;
  logic [DEPTH-1:0][TAG_W-1:0]     tag_a_r;
  logic [DEPTH-1:0][TAG_W-1:0]     tag_b_r;
  logic [DEPTH-1:0][SQN_W-1:0]     sqn_r;
  logic [DEPTH-1:0][FU_W-1:0]      fu_r;
  logic [DEPTH-1:0][PAYLOAD_W-1:0] payload_r;
  logic [CNT_W-1:0]                count_r;

  logic                 out_valid_r;
  logic [TAG_W-1:0]     out_tag_a_r;
  logic [TAG_W-1:0]     out_tag_b_r;
  logic [SQN_W-1:0]     out_sqn_r;
  logic [FU_W-1:0]      out_fu_r;
  logic [PAYLOAD_W-1:0] out_payload_r;

  logic [DEPTH-1:0]     flush_s;
  logic [DEPTH-1:0]     ready_s;
  logic [DEPTH-1:0]     wake_a_s;
  logic [DEPTH-1:0]     wake_b_s;
  logic [DEPTH-1:0]     alloc_s;
  logic                 alloc_found_s;
  logic [DEPTH-1:0]     grant_s;
  logic                 found_s;
  logic                 full_s;
  logic                 enq_s;
  logic                 issue_s;
  logic                 in_avail_a_s;
  logic                 in_avail_b_s;
  logic [CNT_W-1:0]     flush_cnt_s;
  logic [TAG_W-1:0]     sel_tag_a_s;
  logic [TAG_W-1:0]     sel_tag_b_s;
  logic [SQN_W-1:0]     sel_sqn_s;
  logic [FU_W-1:0]      sel_fu_s;
  logic [PAYLOAD_W-1:0] sel_payload_s;

  // Readiness uses start-of-cycle availability; flushed entries are excluded this cycle.
  always_comb begin
    flush_s     = {DEPTH{1'b0}};
    ready_s     = {DEPTH{1'b0}};
    wake_a_s    = {DEPTH{1'b0}};
    wake_b_s    = {DEPTH{1'b0}};
    flush_cnt_s = {CNT_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      flush_s[i]  = IN_invalidate && valid_r[i] && is_younger(sqn_r[i], IN_invalidateSqN);
      ready_s[i]  = valid_r[i] && avail_a_r[i] && avail_b_r[i] && !flush_s[i];
      wake_a_s[i] = wb_hit(tag_a_r[i], IN_wbHasResult, IN_wbTag);
      wake_b_s[i] = wb_hit(tag_b_r[i], IN_wbHasResult, IN_wbTag);
      flush_cnt_s = flush_cnt_s + CNT_W'(flush_s[i]);
    end
  end

  // Lowest-index free slot for an incoming uop.
  always_comb begin
    alloc_s       = {DEPTH{1'b0}};
    alloc_found_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_r[i] && !alloc_found_s) begin
        alloc_s[i]    = 1'b1;
        alloc_found_s = 1'b1;
      end else begin
        alloc_found_s = alloc_found_s;
      end
    end
  end

  iq_age_select #(.DEPTH(DEPTH)) u_age_select (
    .req   (ready_s),
    .sqn   (sqn_r),
    .grant (grant_s),
    .found (found_s)
  );

  assign full_s       = (count_r == CNT_W'(DEPTH));
  assign enq_s        = IN_valid && !full_s && alloc_found_s &&
                        !(IN_invalidate && is_younger(IN_sqN, IN_invalidateSqN));
  assign issue_s      = !IN_stall && found_s;
  assign in_avail_a_s = IN_tagA[CONST_BIT] || wb_hit(IN_tagA, IN_wbHasResult, IN_wbTag);
  assign in_avail_b_s = IN_tagB[CONST_BIT] || wb_hit(IN_tagB, IN_wbHasResult, IN_wbTag);

  // Field mux of the granted entry.
  always_comb begin
    sel_tag_a_s   = {TAG_W{1'b0}};
    sel_tag_b_s   = {TAG_W{1'b0}};
    sel_sqn_s     = {SQN_W{1'b0}};
    sel_fu_s      = {FU_W{1'b0}};
    sel_payload_s = {PAYLOAD_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (grant_s[i]) begin
        sel_tag_a_s   = tag_a_r[i];
        sel_tag_b_s   = tag_b_r[i];
        sel_sqn_s     = sqn_r[i];
        sel_fu_s      = fu_r[i];
        sel_payload_s = payload_r[i];
      end else begin
        sel_fu_s = sel_fu_s;
      end
    end
  end

  // Entry storage: allocate, free on issue or flush, otherwise accumulate wakeups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r   <= {DEPTH{1'b0}};
      avail_a_r <= {DEPTH{1'b0}};
      avail_b_r <= {DEPTH{1'b0}};
      tag_a_r   <= {DEPTH*TAG_W{1'b0}};
      tag_b_r   <= {DEPTH*TAG_W{1'b0}};
      sqn_r     <= {DEPTH*SQN_W{1'b0}};
      fu_r      <= {DEPTH*FU_W{1'b0}};
      payload_r <= {DEPTH*PAYLOAD_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_s && alloc_s[i]) begin
          valid_r[i]   <= 1'b1;
          avail_a_r[i] <= in_avail_a_s;
          avail_b_r[i] <= in_avail_b_s;
          tag_a_r[i]   <= IN_tagA;
          tag_b_r[i]   <= IN_tagB;
          sqn_r[i]     <= IN_sqN;
          fu_r[i]      <= IN_fu;
          payload_r[i] <= IN_payload;
        end else if ((issue_s && grant_s[i]) || flush_s[i]) begin
          valid_r[i] <= 1'b0;
        end else begin
          avail_a_r[i] <= avail_a_r[i] | wake_a_s[i];
          avail_b_r[i] <= avail_b_r[i] | wake_b_s[i];
        end
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_r + CNT_W'(enq_s) - CNT_W'(issue_s) - flush_cnt_s;
    end
  end

  // Issue slot: load on issue, drop on idle, hold under stall unless the held uop is flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r   <= 1'b0;
      out_tag_a_r   <= {TAG_W{1'b0}};
      out_tag_b_r   <= {TAG_W{1'b0}};
      out_sqn_r     <= {SQN_W{1'b0}};
      out_fu_r      <= {FU_W{1'b0}};
      out_payload_r <= {PAYLOAD_W{1'b0}};
    end else if (issue_s) begin
      out_valid_r   <= 1'b1;
      out_tag_a_r   <= sel_tag_a_s;
      out_tag_b_r   <= sel_tag_b_s;
      out_sqn_r     <= sel_sqn_s;
      out_fu_r      <= sel_fu_s;
      out_payload_r <= sel_payload_s;
    end else if (!IN_stall) begin
      out_valid_r <= 1'b0;
    end else if (IN_invalidate && out_valid_r && is_younger(out_sqn_r, IN_invalidateSqN)) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign OUT_full     = full_s;
  assign OUT_count    = count_r;
  assign OUT_uopValid = out_valid_r;
  assign OUT_tagA     = out_tag_a_r;
  assign OUT_tagB     = out_tag_b_r;
  assign OUT_sqN      = out_sqn_r;
  assign OUT_fu       = out_fu_r;
  assign OUT_payload  = out_payload_r;

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: directed stimulus pushes expected issues, a monitor pops and compares.
module tb_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        IN_valid = 1'b0;
  logic [6:0]  IN_tagA = 7'd0, IN_tagB = 7'd0, IN_sqN = 7'd0;
  logic [3:0]  IN_fu = 4'd0;
  logic [31:0] IN_payload = 32'd0;
  logic [3:0]  IN_wbHasResult = 4'd0;
  logic [27:0] IN_wbTag = 28'd0;
  logic        IN_invalidate = 1'b0;
  logic [6:0]  IN_invalidateSqN = 7'd0;
  logic        IN_stall = 1'b0;
  logic        OUT_full;
  logic [3:0]  OUT_count;
  logic        OUT_uopValid;
  logic [6:0]  OUT_tagA, OUT_tagB, OUT_sqN;
  logic [3:0]  OUT_fu;
  logic [31:0] OUT_payload;

  typedef struct packed {
    logic [6:0]  tag_a;
    logic [6:0]  tag_b;
    logic [6:0]  sqn;
    logic [3:0]  fu;
    logic [31:0] payload;
  } uop_t;

  uop_t sb[$];
  int   total = 0;
  int   bad = 0;
  logic stall_q = 1'b0;

  issue_queue dut (
    .clk(clk), .rst_n(rst_n), .IN_valid(IN_valid), .IN_tagA(IN_tagA), .IN_tagB(IN_tagB),
    .IN_sqN(IN_sqN), .IN_fu(IN_fu), .IN_payload(IN_payload), .IN_wbHasResult(IN_wbHasResult),
    .IN_wbTag(IN_wbTag), .IN_invalidate(IN_invalidate), .IN_invalidateSqN(IN_invalidateSqN),
    .IN_stall(IN_stall), .OUT_full(OUT_full), .OUT_count(OUT_count), .OUT_uopValid(OUT_uopValid),
    .OUT_tagA(OUT_tagA), .OUT_tagB(OUT_tagB), .OUT_sqN(OUT_sqN), .OUT_fu(OUT_fu),
    .OUT_payload(OUT_payload)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pay(input logic [6:0] sq);
    return {16'hC0DE, 9'd0, sq};
  endfunction

  // Monitor: a fresh issue is visible in the cycle after an unstalled edge.
  always @(posedge clk) stall_q <= IN_stall;

  always @(negedge clk) begin
    if (rst_n && !stall_q && OUT_uopValid) begin
      uop_t act, exp_u;
      act = '{OUT_tagA, OUT_tagB, OUT_sqN, OUT_fu, OUT_payload};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL issue: got unexpected sqN=%0d, want no issue", OUT_sqN);
      end else begin
        exp_u = sb.pop_front();
        if (act !== exp_u) begin
          bad++;
          $display("FAIL issue: got sqN=%0d fu=%0d tA=%h tB=%h pay=%h, want sqN=%0d fu=%0d tA=%h tB=%h pay=%h",
                   act.sqn, act.fu, act.tag_a, act.tag_b, act.payload,
                   exp_u.sqn, exp_u.fu, exp_u.tag_a, exp_u.tag_b, exp_u.payload);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IN_valid       = 1'b0;
    IN_wbHasResult = 4'd0;
    IN_wbTag       = 28'd0;
    IN_invalidate  = 1'b0;
  endtask

  task automatic drive_uop(input logic [6:0] ta, input logic [6:0] tbg, input logic [6:0] sq,
                           input logic [3:0] f);
    IN_valid   = 1'b1;
    IN_tagA    = ta;
    IN_tagB    = tbg;
    IN_sqN     = sq;
    IN_fu      = f;
    IN_payload = pay(sq);
  endtask

  task automatic expect_uop(input logic [6:0] ta, input logic [6:0] tbg, input logic [6:0] sq,
                            input logic [3:0] f);
    sb.push_back('{ta, tbg, sq, f, pay(sq)});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp_v);
    end
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 60 && sb.size() != 0; c++) tick();
    check(name, sb.size(), 32'd0);
    repeat (4) tick();
  endtask

  initial begin
    logic [6:0] order [8];
    order = '{7'd1, 7'd127, 7'd3, 7'd0, 7'd126, 7'd2, 7'd5, 7'd4};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_count", OUT_count, 32'd0);
    check("rst_valid", OUT_uopValid, 32'd0);
    check("rst_full", OUT_full, 32'd0);
    check("rst_sqn", OUT_sqN, 32'd0);
    check("rst_payload", OUT_payload, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Constant operands: two-cycle latency, count 1 then 0.
    drive_uop(7'h40, 7'h41, 7'd5, 4'd2);
    expect_uop(7'h40, 7'h41, 7'd5, 4'd2);
    tick(); idle();
    @(negedge clk);
    check("lat_count1", OUT_count, 32'd1);
    check("lat_valid_n1", OUT_uopValid, 32'd0);
    tick();
    @(negedge clk);
    check("lat_valid_n2", OUT_uopValid, 32'd1);
    check("lat_count0", OUT_count, 32'd0);
    drain("drain_basic");

    // Pending operand woken one cycle later: sqN 2 issues before sqN 1.
    drive_uop(7'h03, 7'h40, 7'd1, 4'd1);
    expect_uop(7'h40, 7'h41, 7'd2, 4'd3);
    expect_uop(7'h03, 7'h40, 7'd1, 4'd1);
    tick();
    drive_uop(7'h40, 7'h41, 7'd2, 4'd3);
    tick(); idle();
    IN_wbHasResult = 4'b0001;
    IN_wbTag       = {21'd0, 7'h03};
    tick(); idle();
    drain("drain_wakeup");

    // Fill under stall, full behaviour, wrapped age order.
    IN_stall = 1'b1;
    foreach (order[k]) begin
      drive_uop(7'h40, 7'h40, order[k], 4'd4);
      tick();
    end
    idle();
    for (int s = 126; s < 134; s++) expect_uop(7'h40, 7'h40, 7'(s), 4'd4);
    @(negedge clk);
    check("fill_count", OUT_count, 32'd8);
    check("fill_full", OUT_full, 32'd1);
    check("stall_valid", OUT_uopValid, 32'd0);
    check("stall_hold_sqn", OUT_sqN, 32'd1);
    tick();
    drive_uop(7'h40, 7'h40, 7'd6, 4'd4);
    tick(); idle();
    @(negedge clk);
    check("full_ignore", OUT_count, 32'd8);
    check("stall_hold_sqn2", OUT_sqN, 32'd1);
    tick();
    IN_stall = 1'b0;
    drive_uop(7'h40, 7'h40, 7'd7, 4'd4);
    tick(); idle();
    @(negedge clk);
    check("full_issue_enq", OUT_count, 32'd7);
    drain("drain_wrap");

    // Flush under stall with the held output younger than the flush point.
    for (int s = 10; s < 15; s++) begin
      if (s == 13) begin
        drive_uop(7'h40, 7'h41, 7'd13, 4'd5);
        expect_uop(7'h40, 7'h41, 7'd13, 4'd5);
      end else begin
        drive_uop(7'h07, 7'h40, 7'(s), 4'd5);
      end
      tick();
    end
    idle();
    IN_stall         = 1'b1;
    IN_invalidate    = 1'b1;
    IN_invalidateSqN = 7'd11;
    @(negedge clk);
    check("pre_flush_count", OUT_count, 32'd4);
    tick(); idle();
    IN_stall       = 1'b0;
    IN_wbHasResult = 4'b0001;
    IN_wbTag       = {21'd0, 7'h07};
    expect_uop(7'h07, 7'h40, 7'd10, 4'd5);
    expect_uop(7'h07, 7'h40, 7'd11, 4'd5);
    @(negedge clk);
    check("flush_count", OUT_count, 32'd2);
    check("flush_out_valid", OUT_uopValid, 32'd0);
    tick(); idle();
    drain("drain_flush");

    // Same-cycle wakeup on enqueue.
    drive_uop(7'h40, 7'h05, 7'd20, 4'd6);
    IN_wbHasResult = 4'b0100;
    IN_wbTag       = {7'd0, 7'h05, 14'd0};
    expect_uop(7'h40, 7'h05, 7'd20, 4'd6);
    tick(); idle();
    @(negedge clk);
    check("samecyc_valid_n1", OUT_uopValid, 32'd0);
    tick();
    @(negedge clk);
    check("samecyc_valid_n2", OUT_uopValid, 32'd1);
    drain("drain_samecyc");

    // Reset mid-burst.
    drive_uop(7'h40, 7'h40, 7'd30, 4'd7);
    expect_uop(7'h40, 7'h40, 7'd30, 4'd7);
    tick();
    drive_uop(7'h40, 7'h40, 7'd31, 4'd7);
    tick();
    drive_uop(7'h40, 7'h40, 7'd32, 4'd7);
    tick(); idle();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", OUT_uopValid, 32'd0);
    check("midrst_count", OUT_count, 32'd0);
    check("midrst_sqn", OUT_sqN, 32'd0);
    check("midrst_fu", OUT_fu, 32'd0);
    check("midrst_payload", OUT_payload, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_uop(7'h40, 7'h41, 7'd40, 4'd8);
    expect_uop(7'h40, 7'h41, 7'd40, 4'd8);
    tick(); idle();
    @(negedge clk);
    check("post_rst_count", OUT_count, 32'd1);
    drain("drain_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries (power of two, >=2).
REQ-002 SHALL have parameter NUM_WBS, default 4, number of writeback wakeup ports.
REQ-003 SHALL have parameter PAYLOAD_W, default 32, width of the opaque per-uop payload.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port IN_valid  in  1  enqueue request.
REQ-007 SHALL have ports IN_tagA, IN_tagB  in  7 each  operand tags; bit 6 set = constant operand, always ready.
REQ-008 SHALL have ports IN_sqN  in  7, IN_fu  in  4, IN_payload  in  PAYLOAD_W: uop sequence number, functional unit, opaque data.
REQ-009 SHALL have ports IN_wbHasResult  in  NUM_WBS, IN_wbTag  in  NUM_WBS*7: writeback wakeup broadcast.
REQ-010 SHALL have ports IN_invalidate  in  1, IN_invalidateSqN  in  7: flush of uops younger than IN_invalidateSqN.
REQ-011 SHALL have port IN_stall  in  1  operand-load stage cannot accept a new uop.
REQ-012 SHALL have port OUT_full  out  1  queue cannot accept enqueue this cycle.
REQ-013 SHALL have port OUT_count  out  $clog2(DEPTH)+1  registered occupancy.
REQ-014 SHALL have ports OUT_uopValid  out  1, OUT_tagA, OUT_tagB  out  7, OUT_sqN  out  7, OUT_fu  out  4, OUT_payload  out  PAYLOAD_W: registered issue slot toward the operand-load stage.

Function
REQ-015 SHALL define age as $signed(a - b) on 7-bit sqN; "younger than X" means $signed(sqN - X) > 0.
REQ-016 SHALL assert OUT_full combinationally when OUT_count == DEPTH; enqueue accepted iff IN_valid && !OUT_full.
REQ-017 SHALL write an accepted uop to the lowest-index free entry; operand marked available if tag bit 6 set, or any IN_wbHasResult[j] with IN_wbTag[j] == tag in the same cycle.
REQ-018 SHALL set an entry operand available whenever a valid writeback tag matches it; availability never clears while the entry lives.
REQ-019 SHALL treat an entry as ready when both operands are available at the start of the cycle (wakeup in cycle N makes entry eligible in cycle N+1).
REQ-020 SHALL select, among ready valid entries, the oldest by REQ-015; ties broken by lowest index.
REQ-021 SHALL, when !IN_stall and a ready entry exists, load it into the output register and free it at the same edge; OUT_uopValid = 1 next cycle.
REQ-022 SHALL, when !IN_stall and no ready entry, clear OUT_uopValid.
REQ-023 SHALL, when IN_stall, hold all OUT_* issue fields unchanged and issue nothing.
REQ-024 SHALL give minimum latency of 2 cycles: enqueue cycle N with ready operands -> OUT_uopValid at cycle N+2.
REQ-025 SHALL, on IN_invalidate, free every entry younger than IN_invalidateSqN, drop a younger incoming uop, exclude younger entries from selection that cycle, and clear OUT_uopValid if the held output is younger (even under IN_stall).
REQ-026 SHALL update OUT_count as count + enq - issue - flushed, never exceeding DEPTH; enqueue while full is ignored even if an issue frees an entry the same cycle.

Reset
REQ-027 SHALL on rst_n low immediately clear all entry valid bits, OUT_count = 0, OUT_uopValid = 0, OUT_tagA/B, OUT_sqN, OUT_fu, OUT_payload = 0.
REQ-028 SHALL discard in-flight enqueue, wakeup and issue when reset asserts mid-operation; first enqueue accepted in the first cycle after rst_n rises.

Structure
REQ-029 SHALL take tag width (7), sqN width (7), FU width (4) and the constant-tag bit position from the shared core package.
REQ-030 SHALL implement oldest-ready selection as a sub-module iq_age_select (entry valid/ready vector + sqN array -> one-hot grant + found).

Verification
REQ-031 SHALL cover: reset, enqueue tagA=0x40 tagB=0x41 sqN=5 fu=2, no stall -> OUT_uopValid=1 sqN=5 fu=2 exactly 2 cycles later, OUT_count 1 then 0.
REQ-032 SHALL cover: enqueue tagA=0x03 (not ready) sqN=1, then sqN=2 ready; wb tag 0x03 next cycle -> sqN=2 issues first, sqN=1 issues the cycle after the wakeup plus one.
REQ-033 SHALL cover: fill 8 entries with ready uops, IN_stall=1 -> OUT_full=1, extra enqueue ignored, OUT_* held; release stall -> issue order strictly by sqN including wrap sqN 126,127,0,1.
REQ-034 SHALL cover: entries sqN 10..14, output holding sqN 13 under stall, IN_invalidate with sqN 11 -> entries 12,14 freed, OUT_uopValid=0, OUT_count drops accordingly, sqN 10,11 still issue.
REQ-035 SHALL cover: enqueue tagB=0x05 in same cycle as wb tag 0x05 -> entry ready and issued 2 cycles later; rst_n pulled low mid-burst -> outputs zero immediately.
